mux_arb_n: RTL
==============

Name: mux_arb_n

Overview:
N-channel, parametrised successor to the 2:1 data mux. It selects one of NUM_CH valid/ready input streams and drives a single registered output stream. There are two run-time modes: explicit select (sel-driven) and round-robin arbitration. The block sits between multiple producers (adder/datapath lanes) and one shared consumer. It provides one cycle of latency and full throughput under backpressure.

Parameters:
DATA_WIDTH, 32, payload width per channel
NUM_CH, 4, number of input channels (2..16)
SEL_WIDTH, 2, width of sel/out_ch; must be >= clog2(NUM_CH)

Ports:
clk  input  1  clock; all logic rising-edge
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = select mode (sel), 1 = round-robin mode
sel  input  SEL_WIDTH  channel index used in select mode
in_data  input  NUM_CH*DATA_WIDTH  flattened payloads; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready (combinational)
out_data  output  DATA_WIDTH  registered payload
out_ch  output  SEL_WIDTH  registered index of the source channel of out_data
out_valid  output  1  registered output valid
out_ready  input  1  consumer ready

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=NUM_CH-1. Channel 0 therefore has first priority after reset.
- Reset takes effect mid-transfer. Any held output word is discarded, no handshake completes in the reset cycle, and in_ready is all-zero while rst_n=0.
- can_accept = !out_valid | out_ready.
- Grant (combinational, one-hot or zero):
  - Mode 0: grant[sel]=1 iff sel<NUM_CH and in_valid[sel]. If sel>=NUM_CH, there is no grant and the channel is never accepted.
  - Mode 1: search from (rr_ptr+1) mod NUM_CH upward with wrap. The first i with in_valid[i]=1 is granted.
- in_ready[i] = grant[i] & can_accept. At most one bit is set.
- in_ready depends combinationally on in_valid. Producers must not make in_valid depend on in_ready.
- Input transfer: in_valid[i] & in_ready[i] at a clk edge. On transfer, out_data <= in_data[i], out_ch <= i, out_valid <= 1.
- Latency: data accepted at edge k is visible on out_* after edge k.
- Throughput: 1 word/cycle when out_ready=1 continuously. Simultaneous drain and accept in the same cycle is allowed.
- Drain without new accept: out_valid <= 0. out_data and out_ch hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid hold stable, and all in_ready=0.
- Round-robin pointer: rr_ptr <= granted index only on an input transfer in mode 1. Mode-0 transfers do not change rr_ptr.
- Mode or sel changes take effect in the same cycle for the grant. They never alter a word already held in the output register.
- No data loss or duplication: each input transfer produces exactly one output transfer, in acceptance order.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles with all in_valid=1, then release with mode=1, out_ready=1 and all in_data[i]=0x100+i. Required: out_valid=0 and in_ready=0 during reset; first output is 0x100 with out_ch=0 one cycle after release.
- Round-robin fairness: NUM_CH=4, all in_valid=1, mode=1, out_ready=1 for 8 cycles. Required: out_ch sequence 0,1,2,3,0,1,2,3 and one output every cycle.
- Round-robin skip and wrap: in_valid=4'b1010 and rr_ptr=1. Required: channel 3 granted, then channel 1, then channel 3. Channels 0 and 2 never get in_ready.
- Select mode: mode=0, sel=2, in_valid=4'b1111, in_data[2]=0xDEADBEEF. Required: only in_ready[2]=1; output is 0xDEADBEEF with out_ch=2. With sel=5 (SEL_WIDTH=3), all in_ready=0 and out_valid falls to 0 after the drain.
- Backpressure: capture a word, then hold out_ready=0 for 5 cycles while toggling inputs. Required: out_data, out_ch and out_valid stay constant and in_ready=0. Raise out_ready: the held word completes and the next granted word appears the following cycle without a bubble.
- Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0. Required: the next cycle shows out_valid=0 and out_data=0, and after release arbitration restarts from channel 0.

Source files
------------

// File: rtl/mux_arb_n.sv
// N-channel valid/ready stream mux with a registered output stage.
// Channels are chosen by explicit select (mode=0) or round-robin arbitration (mode=1).
module mux_arb_n #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         sel,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_ch,
    output logic                         out_valid,
    input  logic                         out_ready
);

    // Handshake: a word moves on any interface when valid & ready are both high
    // at a rising clk edge. valid never waits on ready; ready may depend on valid.

    logic [NUM_CH-1:0]     grant;
    logic [SEL_WIDTH-1:0]  gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic [SEL_WIDTH-1:0]  rr_ptr;
    logic                  can_accept;
    logic                  accept;

    assign can_accept = !out_valid || out_ready;

    // Select mode grants sel only when it names an existing channel; round-robin
    // searches upward from the channel after the last mode-1 winner, wrapping.
    always_comb begin : grant_logic
        int   idx;
        logic found;
        grant = '0;
        idx   = 0;
        found = 1'b0;
        if (mode == 1'b0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((int'(sel) == i) && in_valid[i]) begin
                    grant[i] = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_CH;
                if (!found && in_valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gnt_idx  = SEL_WIDTH'(i);
                gnt_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready is forced low during reset so no producer sees a handshake then.
    assign in_ready = (can_accept && rst_n) ? grant : '0;
    assign accept   = |in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_WIDTH'(NUM_CH - 1);
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_ch    <= gnt_idx;
                if (mode) begin
                    rr_ptr <= gnt_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
